// File: rtl/pe_pkg.sv
// Shared types and default widths for the systolic processing element.
// Saturating accumulation is selected by defining PE_SATURATE_EN (see pe_acc_add).
package pe_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_ACC_W  = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_t;

endpackage

// File: rtl/pe_acc_add.sv
// Accumulator adder: acc + product at ACC_W+1 bits, MSB flags overflow.
// PE_SATURATE_EN defined clamps the sum to all-ones on overflow; otherwise it wraps.
module pe_acc_add
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [2*DATA_W-1:0] product,
    output logic [ACC_W-1:0]    sum,
    output logic                ovf
);

    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, product};
    assign ovf      = wide_sum[ACC_W];

`ifdef PE_SATURATE_EN
    // Once clamped, further non-negative products keep the sum clamped.
    assign sum = ovf ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    assign sum = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/pe_mac_cell.sv
// Systolic MAC cell: forwards operands right/down, accumulates products per tile.
// Overflow handling (wrap or clamp) follows PE_SATURATE_EN inside pe_acc_add.
module pe_mac_cell
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic              in_valid,
    input  logic              in_last,
    output logic [DATA_W-1:0] pass_right,
    output logic [DATA_W-1:0] pass_down,
    output logic              pass_valid,
    output logic              pass_last,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              result_ovf
);

    generate
        if (ACC_W < 2*DATA_W) begin : g_width_check
            $error("pe_mac_cell: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    pe_state_t           state_reg, state_next;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic                ovf_reg, ovf_next;
    logic [DATA_W-1:0]   pass_right_reg, pass_down_reg;
    logic                pass_valid_reg, pass_last_reg;
    logic [ACC_W-1:0]    result_reg;
    logic                result_valid_reg, result_ovf_reg;

    logic [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]    add_base, add_sum;
    logic                add_ovf, tile_ovf, tile_done;

    assign product  = {{DATA_W{1'b0}}, in1} * {{DATA_W{1'b0}}, in2};
    // A tile's first beat starts from zero rather than the stale accumulator.
    assign add_base = (state_reg == ACCUM) ? acc_reg : '0;
    assign tile_ovf = ((state_reg == ACCUM) & ovf_reg) | add_ovf;

    pe_acc_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_acc_add (
        .acc     (add_base),
        .product (product),
        .sum     (add_sum),
        .ovf     (add_ovf)
    );

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        tile_done  = 1'b0;
        if (in_valid) begin
            if (in_last) begin
                state_next = IDLE;
                acc_next   = '0;
                ovf_next   = 1'b0;
                tile_done  = 1'b1;
            end else begin
                state_next = ACCUM;
                acc_next   = add_sum;
                ovf_next   = tile_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            ovf_reg          <= 1'b0;
            pass_right_reg   <= '0;
            pass_down_reg    <= '0;
            pass_valid_reg   <= 1'b0;
            pass_last_reg    <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            result_ovf_reg   <= 1'b0;
        end else if (en) begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            ovf_reg          <= ovf_next;
            pass_right_reg   <= in1;
            pass_down_reg    <= in2;
            pass_valid_reg   <= in_valid;
            pass_last_reg    <= in_valid & in_last;
            result_valid_reg <= tile_done;
            if (tile_done) begin
                result_reg     <= add_sum;
                result_ovf_reg <= tile_ovf;
            end
        end
    end

    assign pass_right   = pass_right_reg;
    assign pass_down    = pass_down_reg;
    assign pass_valid   = pass_valid_reg;
    assign pass_last    = pass_last_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign result_ovf   = result_ovf_reg;

endmodule

// File: tb/tb_pe_mac_cell.sv
// Scoreboard bench for pe_mac_cell; ACC_W=16 so random tiles overflow often.
// Expectations follow PE_SATURATE_EN when the bench is compiled with it.
module tb_pe_mac_cell;

    localparam int     DATA_W  = 8;
    localparam int     ACC_W   = 16;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam int     PASS_W  = 2*DATA_W + 2;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             ovf;
        int               due;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] in1, in2;
    logic              in_valid, in_last;
    logic [DATA_W-1:0] pass_right, pass_down;
    logic              pass_valid, pass_last;
    logic [ACC_W-1:0]  result;
    logic              result_valid, result_ovf;

    pe_mac_cell #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in1          (in1),
        .in2          (in2),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .pass_right   (pass_right),
        .pass_down    (pass_down),
        .pass_valid   (pass_valid),
        .pass_last    (pass_last),
        .result       (result),
        .result_valid (result_valid),
        .result_ovf   (result_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: true (unbounded) tile sum, and expected outputs.
    longint              tile_sum = 0;
    int                  edge_cnt = 0;
    bit                  edge_en  = 1'b0;
    bit                  started  = 1'b0;
    exp_t                exp_q[$];
    logic [PASS_W-1:0]   pass_q[$];
    logic [PASS_W-1:0]   m_pass = '0;
    logic                m_rv   = 1'b0;
    logic [ACC_W-1:0]    m_res  = '0;
    logic                m_ovf  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pass_right"},   64'(pass_right),   64'd0);
        check({tag, ".pass_down"},    64'(pass_down),    64'd0);
        check({tag, ".pass_valid"},   64'(pass_valid),   64'd0);
        check({tag, ".pass_last"},    64'(pass_last),    64'd0);
        check({tag, ".result"},       64'(result),       64'd0);
        check({tag, ".result_valid"}, 64'(result_valid), 64'd0);
        check({tag, ".result_ovf"},   64'(result_ovf),   64'd0);
    endtask

    // The tile result is the plain sum of its products, wrapped or clamped.
    task automatic close_tile();
        exp_t e;
        e.ovf = (tile_sum > ACC_MAX);
`ifdef PE_SATURATE_EN
        e.res = e.ovf ? ACC_W'(ACC_MAX) : ACC_W'(tile_sum);
`else
        e.res = ACC_W'(tile_sum);
`endif
        e.due = edge_cnt;
        exp_q.push_back(e);
        $display("tile done: sum=%0d expect result=%0d ovf=%0d", tile_sum, e.res, e.ovf);
        tile_sum = 0;
    endtask

    task automatic beat(input bit e, input bit v, input bit l, input int a, input int b);
        @(negedge clk);
        en       = e;
        in_valid = v;
        in_last  = l;
        in1      = DATA_W'(a);
        in2      = DATA_W'(b);
        @(posedge clk);
        edge_en = e;
        if (e) begin
            edge_cnt++;
            pass_q.push_back({DATA_W'(a), DATA_W'(b), v, v & l});
            if (v) begin
                tile_sum += longint'(a) * longint'(b);
                if (l) close_tile();
            end
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_reset");
        tile_sum = 0;
        pass_q.delete();
        exp_q.delete();
        m_pass  = '0;
        m_rv    = 1'b0;
        m_res   = '0;
        m_ovf   = 1'b0;
        edge_en = 1'b0;
        en = 1'b1; in_valid = 1'b1; in_last = 1'b1; in1 = 8'd9; in2 = 8'd9;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1 rst = 1'b1;
    endtask

    // Monitor: advances the expected outputs on each enabled edge and compares every cycle.
    always @(negedge clk) begin
        if (started && rst) begin
            if (edge_en) begin
                if (pass_q.size() == 0) begin
                    check("pass_queue_underflow", 64'd1, 64'd0);
                end else begin
                    m_pass = pass_q.pop_front();
                end
                while (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
                    void'(exp_q.pop_front());
                    check("result_missed", 64'd1, 64'd0);
                end
                if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                    m_rv  = 1'b1;
                    m_res = exp_q[0].res;
                    m_ovf = exp_q[0].ovf;
                    void'(exp_q.pop_front());
                end else begin
                    m_rv = 1'b0;
                end
            end
            check("pass", 64'({pass_right, pass_down, pass_valid, pass_last}), 64'(m_pass));
            check("result_valid", 64'(result_valid), 64'(m_rv));
            check("result", 64'(result), 64'(m_res));
            check("result_ovf", 64'(result_ovf), 64'(m_ovf));
            if (result_valid && edge_en)
                $display("result pulse: result=%0d ovf=%0d", result, result_ovf);
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; in1 = '0; in2 = '0;
        #12 check_all_zero("reset");
        @(negedge clk);
        #1 rst = 1'b1;
        started = 1'b1;

        // Five-beat tile: 6+4+5+0+6 = 21.
        beat(1, 1, 0, 3, 2); beat(1, 1, 0, 1, 4); beat(1, 1, 0, 5, 1);
        beat(1, 1, 0, 0, 7); beat(1, 1, 1, 2, 3);
        beat(1, 0, 0, 0, 0);

        // Back-to-back: single-beat 20 then 4+1 = 5 with no bubble.
        beat(1, 1, 1, 4, 5); beat(1, 1, 0, 2, 2); beat(1, 1, 1, 1, 1);
        beat(1, 0, 0, 0, 0);

        // Gaps and stalls inside a tile, last toggled while invalid or disabled.
        beat(1, 1, 0, 3, 2); beat(1, 0, 1, 9, 9); beat(0, 1, 1, 8, 8);
        beat(1, 1, 0, 1, 4); beat(1, 1, 0, 5, 1); beat(0, 0, 0, 0, 0);
        beat(1, 0, 1, 0, 0); beat(1, 1, 0, 0, 7); beat(1, 1, 1, 2, 3);
        beat(0, 0, 1, 6, 6); beat(0, 1, 1, 6, 6); beat(1, 0, 0, 0, 0);

        // Overflow tile, then a clean tile.
        beat(1, 1, 0, 255, 255); beat(1, 1, 1, 255, 255);
        beat(1, 1, 1, 1, 1); beat(1, 0, 0, 0, 0);

        // Reset in the middle of a tile discards it.
        beat(1, 1, 0, 7, 7); beat(1, 1, 0, 3, 3);
        mid_reset();
        beat(1, 1, 1, 2, 3); beat(1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit e, v, l;
            int a, b;
            e = ($urandom_range(0, 99) < 85);
            v = ($urandom_range(0, 99) < 70);
            l = ($urandom_range(0, 99) < 25);
            a = ($urandom_range(0, 3) == 0) ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255);
            b = ($urandom_range(0, 3) == 0) ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255);
            beat(e, v, l, a, b);
        end
        beat(1, 1, 1, 1, 1);
        beat(1, 0, 0, 0, 0); beat(1, 0, 0, 0, 0); beat(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("pending_results", 64'(exp_q.size()), 64'd0);
        check("pending_pass", 64'(pass_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
